quire_to_posit_4_0: RTL and testbench
=====================================

# quire_to_posit_4_0

Converts the running quire stream from the posit<4,0> accumulator into a rounded 4-bit posit<4,0> result. It sits directly downstream of the accumulator and consumes its rts/rtr stream beat by beat. Only the end-of-window (eow) beat produces an output word; intermediate partial sums are accepted and discarded. The block has a 3-stage pipeline and a one-entry input skid latch, and counts the results it emits.

## Interface
- LOG_NB_ACCUM, 10: accumulation headroom. Quire width QW = 9 + LOG_NB_ACCUM (19 at default).
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- rtr_o  out  1  ready to receive (registered).
- rts_i  in  1  upstream ready to send.
- sow_i  in  1  start of window (carried, not used for arithmetic).
- eow_i  in  1  end of window; marks the beat to convert.
- data_i  in  QW  signed quire, two's complement, LSB weight 2^-4.
- NaR_i  in  1  quire is NaR.
- rtr_i  in  1  downstream ready to receive.
- rts_o  out  1  result valid.
- posit_o  out  4  posit<4,0> result.
- NaR_o  out  1  result is NaR (posit_o = 4'b1000).
- count_o  out  16  number of results emitted, wrapping.

## Operation
- A beat is accepted when rts_i & rtr_o, and enters stage 1 when process_en = rtr_i | ~rts_o.
- Accepted while ~process_en: the beat goes into the skid latch. While the latch is full, stage 1 takes its input from the latch. The latch clears on the next process_en.
- rtr_o <= process_en every cycle.
- Beats with eow=0 enter the pipeline as bubbles (staged=0) and are dropped.
- Stage 1:
  - sign = data_i[QW-1].
  - M = |data_i| held in QW bits, unsigned. The most negative value gives M = 2^(QW-1).
  - zero = (data_i == 0); NaR registered.
- Stage 2: magnitude code c from M, using round-to-nearest-even on the posit encoding and never rounding a nonzero value to zero:
  - M = 0 → 000
  - 1..5 → 001
  - 6..10 → 010
  - 11..13 → 011
  - 14..20 → 100
  - 21..27 → 101
  - 28..48 → 110
  - ≥49 → 111 (saturate to maxpos = 4)
- Stage 3:
  - NaR: posit_o = 1000, NaR_o = 1.
  - Otherwise: posit_o = sign ? (−{0,c}) mod 16 : {0,c}, NaR_o = 0.
  - zero forces posit_o = 0000.
- NaR has priority over zero and sign.
- count_o increments by 1 on each cycle with rts_o & rtr_i, and wraps from 0xFFFF to 0.

## Timing
- Latency: 3 cycles from acceptance of an eow beat (no stall) to rts_o = 1 with its posit_o.
- Throughput: one beat per cycle while rtr_i = 1.
- Every stage advances only on process_en. A stage with no valid entry clears its staged bit on process_en.
- rts_o = staged[2]. posit_o and NaR_o hold stable while rts_o & ~rtr_i.
- Stall: with rtr_i = 0 and rts_o = 1, rtr_o falls one cycle later. At most one beat arrives in that window, and it goes into the skid latch. No beat is lost or duplicated.
- Simultaneous: latch full and process_en asserted in the same cycle → the latched beat moves to stage 1 and a new beat may be accepted directly on the following cycle.
- Reset (sync, rst_n = 0 at a clk edge), including mid-stream:
  - rts_o = 0, rtr_o = 0, posit_o = 0000, NaR_o = 0, count_o = 0.
  - All staged bits and the latch are cleared; in-flight beats are discarded.
  - rtr_o = 1 on the first edge after rst_n returns high.

## Test plan
- Values, each sent as a single sow+eow beat with rtr_i = 1. Expected posit_o 3 cycles later:
  - data_i 16 → 0100
  - data_i 0 → 0000
  - data_i 1 → 0001
  - data_i 6 → 0010
  - data_i 48 → 0110
  - data_i 49 → 0111
  - data_i −24 → 1011
  - data_i −2^18 → 1001
- Rounding ties: data_i 10, 14, 20, 28 → 0010, 0100, 0100, 0110 respectively.
- NaR: NaR_i = 1 with data_i = 0 and eow → posit_o = 1000, NaR_o = 1.
- Window filtering: send 8 beats with eow only on the 8th (data_i = −3) → exactly one output, 1111; count_o goes 0 → 1.
- Backpressure: stream 6 eow beats with rtr_i toggling 1,0,0,1,… → all 6 results appear in order with no loss or duplication, and outputs stay stable while stalled.
- Reset mid-stream: assert rst_n = 0 for 1 cycle with 2 beats in flight → no rts_o afterwards, count_o = 0, rtr_o = 1 one cycle after release.

Source files
------------

// File: rtl/quire_to_posit_4_0.sv
// Quire-to-posit<4,0> converter: a 3-stage pipeline with a one-entry skid latch.
// It converts only end-of-window beats and counts the results it emits.
module quire_to_posit_4_0 #(
    parameter int LOG_NB_ACCUM = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     rtr_o,
    input  logic                     rts_i,
    input  logic                     sow_i,
    input  logic                     eow_i,
    input  logic [9+LOG_NB_ACCUM-1:0] data_i,
    input  logic                     NaR_i,
    input  logic                     rtr_i,
    output logic                     rts_o,
    output logic [3:0]               posit_o,
    output logic                     NaR_o,
    output logic [15:0]              count_o
);
    localparam int QW = 9 + LOG_NB_ACCUM;

    logic          process_en;
    logic          accept;
    logic          skid_full;
    logic          skid_eow;
    logic          skid_nar;
    logic [QW-1:0] skid_data;

    logic          in_valid;
    logic          in_eow;
    logic          in_nar;
    logic [QW-1:0] in_data;

    logic          s1_staged, s1_sign, s1_zero, s1_nar;
    logic [QW-1:0] s1_mag;
    logic          s2_staged, s2_sign, s2_zero, s2_nar;
    logic [2:0]    s2_code;
    logic [2:0]    code_d;
    logic [3:0]    posit_d;

    // sow only delimits windows upstream; nothing in this block depends on it.
    logic unused_sow;
    assign unused_sow = sow_i;

    assign process_en = rtr_i | ~rts_o;
    assign accept     = rts_i & rtr_o;

    // The latch, when full, always holds the oldest beat, so it feeds stage 1 first.
    assign in_valid = skid_full | accept;
    assign in_eow   = skid_full ? skid_eow  : eow_i;
    assign in_nar   = skid_full ? skid_nar  : NaR_i;
    assign in_data  = skid_full ? skid_data : data_i;

    // Round-to-nearest-even on the posit encoding; nonzero never rounds to zero.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves code_d unassigned (no latch).
        code_d = 3'd7;
        if      (s1_mag == '0)         code_d = 3'd0;
        else if (s1_mag <= QW'(5))     code_d = 3'd1;
        else if (s1_mag <= QW'(10))    code_d = 3'd2;
        else if (s1_mag <= QW'(13))    code_d = 3'd3;
        else if (s1_mag <= QW'(20))    code_d = 3'd4;
        else if (s1_mag <= QW'(27))    code_d = 3'd5;
        else if (s1_mag <= QW'(48))    code_d = 3'd6;
    end

    always_comb begin
        posit_d = s2_sign ? 4'(-{1'b0, s2_code}) : {1'b0, s2_code};
        if (s2_zero) posit_d = 4'b0000;
        if (s2_nar)  posit_d = 4'b1000;
    end

    // Control state and outputs: everything that must be known after reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            rtr_o     <= 1'b0;
            skid_full <= 1'b0;
            s1_staged <= 1'b0;
            s2_staged <= 1'b0;
            rts_o     <= 1'b0;
            posit_o   <= 4'b0000;
            NaR_o     <= 1'b0;
            count_o   <= 16'd0;
        end else begin
            rtr_o <= process_en;
            if (process_en)
                skid_full <= 1'b0;
            else if (accept)
                skid_full <= 1'b1;
            if (process_en) begin
                s1_staged <= in_valid & in_eow;
                s2_staged <= s1_staged;
                rts_o     <= s2_staged;
                posit_o   <= posit_d;
                NaR_o     <= s2_nar;
            end
            if (rts_o && rtr_i)
                count_o <= count_o + 16'd1;
        end
    end

    // Payload registers: qualified by the staged bits, so they carry no reset.
    always_ff @(posedge clk) begin
        // NOTE: data storage is left unreset on purpose; the valid flags alone decide if it matters.
        if (!process_en && accept && !skid_full) begin
            skid_eow  <= eow_i;
            skid_nar  <= NaR_i;
            skid_data <= data_i;
        end
        if (process_en) begin
            s1_sign <= in_data[QW-1];
            s1_mag  <= in_data[QW-1] ? QW'(-in_data) : in_data;
            s1_zero <= (in_data == '0);
            s1_nar  <= in_nar;
            s2_sign <= s1_sign;
            s2_code <= code_d;
            s2_zero <= s1_zero;
            s2_nar  <= s1_nar;
        end
    end
endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Directed self-checking bench for quire_to_posit_4_0 with hand-computed expected posits.
module tb_quire_to_posit_4_0;
    localparam int QW = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rtr_o;
    logic          rts_i = 1'b0;
    logic          sow_i = 1'b0;
    logic          eow_i = 1'b0;
    logic [QW-1:0] data_i = '0;
    logic          NaR_i = 1'b0;
    logic          rtr_i = 1'b1;
    logic          rts_o;
    logic [3:0]    posit_o;
    logic          NaR_o;
    logic [15:0]   count_o;

    int compared = 0;
    int mismatched = 0;

    quire_to_posit_4_0 #(.LOG_NB_ACCUM(10)) dut (
        .clk(clk), .rst_n(rst_n), .rtr_o(rtr_o), .rts_i(rts_i), .sow_i(sow_i),
        .eow_i(eow_i), .data_i(data_i), .NaR_i(NaR_i), .rtr_i(rtr_i),
        .rts_o(rts_o), .posit_o(posit_o), .NaR_o(NaR_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rts_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // One sow+eow beat with rtr_i=1; result must appear exactly 3 cycles after acceptance.
    task automatic send_one(input string tag, input int d, input logic nar,
                            input logic [3:0] exp_posit, input logic exp_nar);
        rtr_i  = 1'b1;
        rts_i  = 1'b1;
        sow_i  = 1'b1;
        eow_i  = 1'b1;
        data_i = QW'(d);
        NaR_i  = nar;
        check({tag, "_rtr"}, rtr_o, 1'b1);
        step();
        rts_i = 1'b0;
        sow_i = 1'b0;
        eow_i = 1'b0;
        NaR_i = 1'b0;
        step();
        check({tag, "_early"}, rts_o, 1'b0);
        step();
        check({tag, "_rts"}, rts_o, 1'b1);
        check({tag, "_posit"}, posit_o, exp_posit);
        check({tag, "_nar"}, NaR_o, exp_nar);
        step();
    endtask

    int          bp_data [6] = '{1, 6, 16, -24, 49, -3};
    logic [3:0]  bp_exp  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1011, 4'b0111, 4'b1111};

    initial begin
        int n_out;
        logic [3:0] last;
        int src;
        int got;
        logic hold_valid;
        logic [3:0] held;
        logic acc;

        // Reset state
        step();
        step();
        check("rst_rts", rts_o, 1'b0);
        check("rst_rtr", rtr_o, 1'b0);
        check("rst_posit", posit_o, 4'b0000);
        check("rst_nar", NaR_o, 1'b0);
        check("rst_count", count_o, 16'd0);
        rst_n = 1'b1;
        step();
        check("rst_release_rtr", rtr_o, 1'b1);

        // Value table
        send_one("v16", 16, 1'b0, 4'b0100, 1'b0);
        send_one("v0", 0, 1'b0, 4'b0000, 1'b0);
        send_one("v1", 1, 1'b0, 4'b0001, 1'b0);
        send_one("v6", 6, 1'b0, 4'b0010, 1'b0);
        send_one("v48", 48, 1'b0, 4'b0110, 1'b0);
        send_one("v49", 49, 1'b0, 4'b0111, 1'b0);
        send_one("vm24", -24, 1'b0, 4'b1011, 1'b0);
        send_one("vmin", -(1 << 18), 1'b0, 4'b1001, 1'b0);
        send_one("tie10", 10, 1'b0, 4'b0010, 1'b0);
        send_one("tie14", 14, 1'b0, 4'b0100, 1'b0);
        send_one("tie20", 20, 1'b0, 4'b0100, 1'b0);
        send_one("tie28", 28, 1'b0, 4'b0110, 1'b0);
        send_one("nar", 0, 1'b1, 4'b1000, 1'b1);
        send_one("nar_data", -24, 1'b1, 4'b1000, 1'b1);
        check("count_values", count_o, 16'd14);

        // Window filtering: 8 beats, eow only on the last
        do_reset();
        check("win_count0", count_o, 16'd0);
        n_out = 0;
        last  = 4'b0000;
        rtr_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rts_i  = 1'b1;
            sow_i  = (i == 0);
            eow_i  = (i == 7);
            data_i = (i == 7) ? QW'(-3) : QW'(5 + i);
            if (rts_o) begin n_out++; last = posit_o; end
            step();
        end
        rts_i = 1'b0;
        eow_i = 1'b0;
        sow_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rts_o) begin n_out++; last = posit_o; end
            step();
        end
        check("win_outputs", n_out, 1);
        check("win_posit", last, 4'b1111);
        check("win_count1", count_o, 16'd1);

        // Backpressure: rtr_i = 1,0,0 repeating
        src = 0;
        got = 0;
        hold_valid = 1'b0;
        held = 4'b0000;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            rtr_i  = (cyc % 3 == 0);
            rts_i  = (src < 6);
            sow_i  = 1'b1;
            eow_i  = 1'b1;
            data_i = (src < 6) ? QW'(bp_data[src]) : '0;
            if (hold_valid) check("bp_stable", posit_o, held);
            if (rts_o && rtr_i) begin
                check("bp_posit", posit_o, bp_exp[got]);
                got++;
            end
            hold_valid = rts_o & ~rtr_i;
            held = posit_o;
            acc = rts_i & rtr_o;
            step();
            if (acc) src++;
        end
        rts_i = 1'b0;
        eow_i = 1'b0;
        sow_i = 1'b0;
        rtr_i = 1'b1;
        check("bp_got", got, 6);
        check("bp_sent", src, 6);
        n_out = 0;
        for (int i = 0; i < 6; i++) begin
            if (rts_o) n_out++;
            step();
        end
        check("bp_no_dup", n_out, 0);
        check("bp_count", count_o, 16'd7);

        // Reset mid-stream with 2 beats in flight
        rtr_i  = 1'b1;
        rts_i  = 1'b1;
        eow_i  = 1'b1;
        sow_i  = 1'b1;
        data_i = QW'(16);
        step();
        data_i = QW'(6);
        step();
        rts_i = 1'b0;
        eow_i = 1'b0;
        sow_i = 1'b0;
        rst_n = 1'b0;
        step();
        check("mid_rts", rts_o, 1'b0);
        check("mid_rtr", rtr_o, 1'b0);
        check("mid_count", count_o, 16'd0);
        check("mid_posit", posit_o, 4'b0000);
        check("mid_nar", NaR_o, 1'b0);
        rst_n = 1'b1;
        step();
        check("mid_release_rtr", rtr_o, 1'b1);
        n_out = 0;
        for (int i = 0; i < 6; i++) begin
            if (rts_o) n_out++;
            step();
        end
        check("mid_no_output", n_out, 0);
        check("mid_count_after", count_o, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
